// File: rtl/prog_mem_pkg.sv
// Shared definitions for the writable program memory: loader states, the
// default NOP instruction word and word/byte helpers.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_RECV  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_e;

    // Opcode field of the no-operation instruction used across the CPU.
    localparam logic [5:0]  NOP              = 6'h3E;
    localparam logic [15:0] NOP_WORD_DEFAULT = {NOP, 10'h000};

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/prog_mem_loader.sv
// Byte-serial program loader: assembles big-endian words from the load
// interface and issues one memory write per completed word.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              LdStart,
    input  logic [ADDR_W:0]   LdWords,
    input  logic [7:0]        LdByte,
    input  logic              LdValid,
    output logic              LdReady,
    output logic              LdBusy,
    output logic              LdDone,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int              BPW       = bytes_per_word(DATA_W);
    localparam int              BC_W      = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BPW - 1);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ZERO_L    = {(ADDR_W + 1){1'b0}};

    ld_state_e         state_r;
    ld_state_e         state_nxt_s;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   addr_r;
    logic [ADDR_W:0]   addr_inc_s;
    logic [ADDR_W:0]   clamp_s;
    logic [BC_W-1:0]   byte_cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic              accept_s;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;

    assign addr_inc_s = addr_r + {{ADDR_W{1'b0}}, 1'b1};
    assign clamp_s    = (LdWords > DEPTH_L) ? DEPTH_L : LdWords;

    // Next-state decode and byte-accept strobe.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            LD_IDLE: begin
                if (LdStart) begin
                    state_nxt_s = (clamp_s == ZERO_L) ? LD_DONE : LD_RECV;
                end else begin
                    state_nxt_s = LD_IDLE;
                end
            end
            LD_RECV: begin
                accept_s = LdValid;
                if (LdValid && (byte_cnt_r == LAST_BYTE)) begin
                    state_nxt_s = LD_WRITE;
                end else begin
                    state_nxt_s = LD_RECV;
                end
            end
            LD_WRITE: begin
                if (addr_inc_s == count_r) begin
                    state_nxt_s = LD_DONE;
                end else begin
                    state_nxt_s = LD_RECV;
                end
            end
            LD_DONE: state_nxt_s = LD_IDLE;
            default: state_nxt_s = LD_IDLE;
        endcase
    end

    // State, counters, byte assembler and registered handshake outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= LD_IDLE;
            count_r    <= ZERO_L;
            addr_r     <= ZERO_L;
            byte_cnt_r <= {BC_W{1'b0}};
            shift_r    <= {DATA_W{1'b0}};
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == LD_RECV);
            busy_r  <= (state_nxt_s != LD_IDLE);
            done_r  <= (state_nxt_s == LD_DONE);
            if ((state_r == LD_IDLE) && LdStart) begin
                count_r    <= clamp_s;
                addr_r     <= ZERO_L;
                byte_cnt_r <= {BC_W{1'b0}};
            end else if (accept_s) begin
                // Shift left so the first byte of a word lands in the MSBs.
                shift_r    <= DATA_W'({shift_r, LdByte});
                byte_cnt_r <= (byte_cnt_r == LAST_BYTE) ? {BC_W{1'b0}}
                                                        : byte_cnt_r + {{(BC_W-1){1'b0}}, 1'b1};
            end else if (state_r == LD_WRITE) begin
                addr_r <= addr_inc_s;
            end
        end
    end

    assign LdReady = ready_r;
    assign LdBusy  = busy_r;
    assign LdDone  = done_r;
    assign wr_en   = (state_r == LD_WRITE);
    assign wr_addr = addr_r[ADDR_W-1:0];
    assign wr_data = shift_r;

endmodule

// File: rtl/prog_mem.sv
// Writable instruction memory with registered fetch, stall and load lockout.
// Optional per-word even parity is enabled with PROG_MEM_PARITY_EN.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Ip,
    input  logic              Stall,
    output logic [DATA_W-1:0] Instr,
    output logic              InstrValid,
    input  logic              LdStart,
    input  logic [ADDR_W:0]   LdWords,
    input  logic [7:0]        LdByte,
    input  logic              LdValid,
    output logic              LdReady,
    output logic              LdBusy,
    output logic              LdDone,
    output logic              ParityErr
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              in_range_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              perr_nxt_s;
    logic [DATA_W-1:0] instr_r;
    logic              valid_r;
    logic              perr_r;

    // Power-up image is all NOPs; Reset deliberately leaves the contents alone.
    logic [DATA_W-1:0] mem_r [DEPTH] = '{default: NOP_WORD};
`ifdef PROG_MEM_PARITY_EN
    logic              par_mem_r [DEPTH] = '{default: even_parity(64'(NOP_WORD))};
`endif

    prog_mem_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_loader (
        .Clock   (Clock),
        .Reset   (Reset),
        .LdStart (LdStart),
        .LdWords (LdWords),
        .LdByte  (LdByte),
        .LdValid (LdValid),
        .LdReady (LdReady),
        .LdBusy  (LdBusy),
        .LdDone  (LdDone),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s)
    );

    // Array write port driven by the loader.
    always_ff @(posedge Clock) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
`ifdef PROG_MEM_PARITY_EN
            par_mem_r[wr_addr_s] <= even_parity(64'(wr_data_s));
`endif
        end
    end

    assign in_range_s = ({1'b0, Ip} < DEPTH_L);

    // Read mux with out-of-range substitution and parity recheck.
    always_comb begin
        rd_word_s  = NOP_WORD;
        perr_nxt_s = 1'b0;
        if (in_range_s) begin
            rd_word_s = mem_r[Ip];
`ifdef PROG_MEM_PARITY_EN
            perr_nxt_s = (par_mem_r[Ip] != even_parity(64'(mem_r[Ip])));
`else
            perr_nxt_s = 1'b0;
`endif
        end else begin
            rd_word_s  = NOP_WORD;
            perr_nxt_s = 1'b0;
        end
    end

    // Fetch register: loads lock fetch out, stall holds the last word.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
        end else if (LdBusy) begin
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
        end else if (!Stall) begin
            instr_r <= rd_word_s;
            valid_r <= 1'b1;
            perr_r  <= perr_nxt_s;
        end
    end

    assign Instr      = instr_r;
    assign InstrValid = valid_r;
    assign ParityErr  = perr_r;

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: directed and randomized loads and fetches
// compared against an array model of the program memory.
module tb_prog_mem;
    import prog_mem_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1024;
    localparam logic [15:0] NOP_W = NOP_WORD_DEFAULT;

    logic              Clock;
    logic              Reset;
    logic [ADDR_W-1:0] Ip;
    logic              Stall;
    logic [DATA_W-1:0] Instr;
    logic              InstrValid;
    logic              LdStart;
    logic [ADDR_W:0]   LdWords;
    logic [7:0]        LdByte;
    logic              LdValid;
    logic              LdReady;
    logic              LdBusy;
    logic              LdDone;
    logic              ParityErr;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_mem [DEPTH];
    logic [7:0]  ld_bytes [2100];

    prog_mem dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Ip         (Ip),
        .Stall      (Stall),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .LdStart    (LdStart),
        .LdWords    (LdWords),
        .LdByte     (LdByte),
        .LdValid    (LdValid),
        .LdReady    (LdReady),
        .LdBusy     (LdBusy),
        .LdDone     (LdDone),
        .ParityErr  (ParityErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_check(input int ip, input logic exp_perr, input string tag);
        Ip    = ADDR_W'(ip);
        Stall = 1'b0;
        tick();
        check({tag, " instr"}, 32'(Instr), 32'(model_mem[ip]));
        check({tag, " valid"}, 32'(InstrValid), 32'd1);
        check({tag, " perr"}, 32'(ParityErr), 32'(exp_perr));
    endtask

    // mode 0: LdValid always high, 1: toggling, 2: random
    task automatic do_load(input int n_words, input int n_feed, input int mode,
                           output int consumed, output int pulses, output int busy_valid);
        int  cyc;
        bit  ph;
        bit  acc;
        LdWords = (ADDR_W + 1)'(n_words);
        LdStart = 1'b1;
        tick();
        LdStart    = 1'b0;
        consumed   = 0;
        pulses     = int'(LdDone);
        busy_valid = 0;
        cyc        = 0;
        ph         = 1'b1;
        while (LdBusy && cyc < 6000) begin
            if (consumed < n_feed) begin
                LdByte  = ld_bytes[consumed];
                LdValid = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
            end else begin
                LdValid = 1'b0;
            end
            acc = LdValid && LdReady;
            ph  = ~ph;
            tick();
            cyc++;
            if (acc) consumed++;
            if (LdDone) pulses++;
            if (LdBusy && InstrValid) busy_valid++;
        end
        LdValid = 1'b0;
        check("load timeout", 32'(cyc < 6000), 32'd1);
    endtask

    // Words land big-endian, two bytes each, up to the clamped count.
    task automatic model_load(input int n_words);
        int n;
        n = (n_words > DEPTH) ? DEPTH : n_words;
        for (int w = 0; w < n; w++) begin
            model_mem[w] = ld_bytes[2*w] * 256 + ld_bytes[2*w+1];
        end
    endtask

    initial begin
        int consumed;
        int pulses;
        int busy_valid;
        int n;
        int ip;
        bit st;
        logic [15:0] held;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP_W;
        Reset   = 1'b1;
        Ip      = '0;
        Stall   = 1'b0;
        LdStart = 1'b0;
        LdWords = '0;
        LdByte  = 8'h00;
        LdValid = 1'b0;
        tick();
        tick();
        check("rst instr", 32'(Instr), 32'(NOP_W));
        check("rst valid", 32'(InstrValid), 32'd0);
        check("rst ready", 32'(LdReady), 32'd0);
        check("rst busy", 32'(LdBusy), 32'd0);
        check("rst done", 32'(LdDone), 32'd0);
        check("rst perr", 32'(ParityErr), 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 4; i++) fetch_check(i, 1'b0, "nop fetch");

        // Directed two-word load
        ld_bytes[0] = 8'h1A; ld_bytes[1] = 8'h2B; ld_bytes[2] = 8'h3C; ld_bytes[3] = 8'h4D;
        do_load(2, 4, 0, consumed, pulses, busy_valid);
        model_load(2);
        check("ld2 bytes", 32'(consumed), 32'd4);
        check("ld2 done pulses", 32'(pulses), 32'd1);
        check("ld2 busy valid", 32'(busy_valid), 32'd0);
        check("ld2 model word1", 32'(model_mem[1]), 32'h3C4D);
        fetch_check(1, 1'b0, "ld2 ip1");
        fetch_check(0, 1'b0, "ld2 ip0");

        // Three-word load with LdValid toggling every cycle
        for (int i = 0; i < 6; i++) ld_bytes[i] = 8'($urandom);
        do_load(3, 6, 1, consumed, pulses, busy_valid);
        model_load(3);
        check("ld3 bytes", 32'(consumed), 32'd6);
        check("ld3 done pulses", 32'(pulses), 32'd1);
        check("ld3 busy valid", 32'(busy_valid), 32'd0);
        for (int i = 0; i < 3; i++) fetch_check(i, 1'b0, "ld3 fetch");

        // Stall holds the pre-stall word while Ip moves
        fetch_check(0, 1'b0, "pre stall");
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Ip = ADDR_W'(i);
            tick();
            check("stall hold", 32'(Instr), 32'(model_mem[0]));
            check("stall valid", 32'(InstrValid), 32'd1);
        end
        Stall = 1'b0;
        tick();
        check("unstall", 32'(Instr), 32'(model_mem[2]));

        // Zero-word load goes straight to DONE
        do_load(0, 0, 0, consumed, pulses, busy_valid);
        check("ld0 done pulses", 32'(pulses), 32'd1);
        check("ld0 bytes", 32'(consumed), 32'd0);
        for (int i = 0; i < 3; i++) fetch_check(i, 1'b0, "ld0 fetch");

        // Reset after the third byte of a two-word load
        ld_bytes[0] = 8'h55; ld_bytes[1] = 8'h66; ld_bytes[2] = 8'h77; ld_bytes[3] = 8'h88;
        LdWords = 11'd2;
        LdStart = 1'b1;
        tick();
        LdStart  = 1'b0;
        consumed = 0;
        n        = 0;
        while (consumed < 3 && n < 100) begin
            LdByte  = ld_bytes[consumed];
            LdValid = 1'b1;
            st      = LdReady;
            tick();
            n++;
            if (st) consumed++;
        end
        LdValid = 1'b0;
        Reset   = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort bytes", 32'(consumed), 32'd3);
        check("abort busy", 32'(LdBusy), 32'd0);
        check("abort ready", 32'(LdReady), 32'd0);
        model_mem[0] = 16'h5566;
        fetch_check(0, 1'b0, "abort word0");
        fetch_check(1, 1'b0, "abort word1");
        LdWords = 11'd0;
        LdStart = 1'b1;
        tick();
        LdStart = 1'b0;
        check("abort idle restart", 32'(LdDone), 32'd1);
        tick();

        // Random loads with random LdValid
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < 2*n; i++) ld_bytes[i] = 8'($urandom);
            do_load(n, 2*n, 2, consumed, pulses, busy_valid);
            model_load(n);
            check("rnd bytes", 32'(consumed), 32'(2*n));
            check("rnd done pulses", 32'(pulses), 32'd1);
            check("rnd busy valid", 32'(busy_valid), 32'd0);
            for (int i = 0; i < n; i++) fetch_check(i, 1'b0, "rnd fetch");
        end

        // Word count above DEPTH is clamped; extra bytes are not consumed
        for (int i = 0; i < 2100; i++) ld_bytes[i] = 8'($urandom);
        do_load(2047, 2100, 0, consumed, pulses, busy_valid);
        model_load(2047);
        check("clamp bytes", 32'(consumed), 32'd2048);
        check("clamp done pulses", 32'(pulses), 32'd1);
        fetch_check(DEPTH - 1, 1'b0, "clamp last");

        // Random fetch with random stall
        held = model_mem[DEPTH - 1];
        for (int k = 0; k < 40; k++) begin
            ip    = $urandom_range(0, DEPTH - 1);
            st    = ($urandom_range(0, 3) == 0);
            Ip    = ADDR_W'(ip);
            Stall = st;
            tick();
            if (!st) held = model_mem[ip];
            check("rnd stall instr", 32'(Instr), 32'(held));
        end
        Stall = 1'b0;

`ifdef PROG_MEM_PARITY_EN
        dut.mem_r[5] = dut.mem_r[5] ^ 16'h0004;
        model_mem[5] = model_mem[5] ^ 16'h0004;
        fetch_check(5, 1'b1, "parity bad");
        fetch_check(4, 1'b0, "parity good");
`else
        fetch_check(5, 1'b0, "noparity ip5");
        fetch_check(4, 1'b0, "noparity ip4");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised, writable program memory that supplies instruction words to the CPU fetch stage. It replaces the fixed case-table instruction ROM with a `DEPTH`-word array that a byte-serial loader fills at run time, and adds fetch stall support and a fetch-valid flag. It sits between the fetch stage (`Ip` in, `Instr` out) and the external program-load interface.

## Interface
- `ADDR_W`, 10: fetch address width.
- `DATA_W`, 16: instruction width. Must be a multiple of 8.
- `DEPTH`, 1024: number of words. Must be ≤ 2^ADDR_W.
- `NOP_WORD`, `{`NOP, 10'h0}`: word returned for idle, out-of-range and reset conditions.

Ports:
- `Clock` in 1: single clock; all logic on posedge.
- `Reset` in 1: synchronous, active-high.
- `Ip` in ADDR_W: fetch address.
- `Stall` in 1: hold `Instr`/`InstrValid`.
- `Instr` out DATA_W: registered instruction.
- `InstrValid` out 1: `Instr` holds a real fetched word.
- `LdStart` in 1: start-load pulse; sampled only in IDLE.
- `LdWords` in ADDR_W+1: number of words to load.
- `LdByte` in 8: load data byte.
- `LdValid` in 1: `LdByte` valid.
- `LdReady` out 1: loader accepts a byte this cycle.
- `LdBusy` out 1: a load is in progress (state ≠ IDLE).
- `LdDone` out 1: one-cycle pulse at load completion.
- `ParityErr` out 1: parity mismatch on the current `Instr`; see Configuration.

## Operation
- Loader FSM has four states: IDLE, RECV, WRITE, DONE.
- **IDLE**
  - `LdStart`=1 latches `min(LdWords, DEPTH)` as the word count, clears the write address and byte counter.
  - Count = 0 → DONE. Otherwise → RECV.
- **RECV**
  - `LdReady`=1. A byte is accepted when `LdValid && LdReady`.
  - Bytes are assembled big-endian: the first byte of a word goes to `[DATA_W-1:DATA_W-8]`.
  - After byte `DATA_W/8` of a word is accepted → WRITE.
  - `LdValid` while `LdReady`=0 is ignored; the byte is not consumed.
- **WRITE**
  - One cycle. Writes the assembled word to `mem[addr]` and increments `addr`. `LdReady`=0.
  - `addr` = count → DONE. Otherwise → RECV.
- **DONE**
  - One cycle. `LdDone`=1, then → IDLE.
- `LdStart` outside IDLE is ignored.
- **Fetch while not busy**
  - Every posedge with `Stall`=0: `Instr` ← `mem[Ip]`, or `NOP_WORD` if `Ip` ≥ `DEPTH`; `InstrValid` ← 1.
  - `Stall`=1 holds both outputs.
- **Fetch while `LdBusy`**
  - `Instr` ← `NOP_WORD`, `InstrValid` ← 0, regardless of `Stall`.
- **Memory contents**
  - Initialised to `NOP_WORD` at power-up.
  - Not cleared by `Reset`.
- **Reset**
  - `Instr`=`NOP_WORD`; `InstrValid`, `LdReady`, `LdBusy`, `LdDone`, `ParityErr` = 0; FSM in IDLE.
- **Reset mid-load**
  - Aborts the load. Words already written remain. A partially assembled word is discarded.

## Timing
- Fetch latency is 1 cycle: `Ip` presented at edge N → `Instr` valid after edge N+1.
- Load cost is `DATA_W/8` accepted-byte cycles plus 1 WRITE cycle per word, plus 1 DONE cycle.
- `LdBusy` rises the cycle after `LdStart` is sampled. It falls the cycle after DONE.
- First valid fetch after a load: `Ip` sampled on the edge after DONE; `InstrValid`=1 one cycle later.
- `LdDone` and `LdBusy` are never both 0 while in DONE; `LdBusy`=1 throughout DONE.

## Configuration
- Macro: `PROG_MEM_PARITY_EN`.
- **Defined**
  - Each word stores one extra bit: even parity computed at WRITE.
  - On fetch, `ParityErr` is registered alongside `Instr`: 1 when stored parity ≠ recomputed parity.
  - `Instr` is delivered unmodified. `ParityErr` is 0 for `NOP_WORD` substitutions and when `Stall` holds a clean word.
- **Undefined**
  - No extra storage; `ParityErr` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `prog_mem_pkg` holds:
  - the loader state enum (IDLE/RECV/WRITE/DONE);
  - the default `NOP_WORD` built from the shared `NOP` opcode constant;
  - a bytes-per-word function (`DATA_W/8`).
- Sub-module `prog_mem_loader` contains the FSM, byte assembler, address/count registers, and the `LdReady`/`LdBusy`/`LdDone` outputs. It drives the write enable, address and data.
- The top level holds the array, the fetch register, and the parity logic.

## Test plan
- Reset, then fetch `Ip`=0..3 with no load → `Instr`=`NOP_WORD`, `InstrValid`=1 from the second cycle.
- Load `LdWords`=2 with bytes 1A,2B,3C,4D → `mem[0]`=16'h1A2B, `mem[1]`=16'h3C4D; `LdDone` pulses once; fetch `Ip`=1 → 16'h3C4D one cycle later.
- `LdValid` toggled 1/0 every cycle during a 3-word load → exactly 6 bytes consumed, stored words correct, `InstrValid`=0 throughout `LdBusy`.
- `Stall`=1 for 3 cycles while `Ip` changes 0→1→2 → `Instr` holds the pre-stall word; `Stall`=0 → `mem[2]` appears next cycle.
- `LdWords`=0 → DONE next cycle, `LdDone`=1, memory unchanged. `Reset` after byte 3 of a 2-word load → `mem[0]` written, `mem[1]` unchanged, FSM IDLE.
- With `PROG_MEM_PARITY_EN`, force-flip one stored bit of `mem[5]`, fetch `Ip`=5 → `ParityErr`=1 for one cycle; fetch `Ip`=4 → `ParityErr`=0.
